// File: rtl/neuron_mac_seq.sv
// Neuron MAC sequencer: walks N_INPUTS input/weight pairs through one shared
// external multiplier, then adds bias, applies optional ReLU and quantizes.
module neuron_mac_seq #(
  parameter int unsigned N_INPUTS  = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned OUT_SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       bias,
  input  logic              relu_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        x_in,
  input  logic [7:0]        w_in,
  output logic [7:0]        mult_a,
  output logic [7:0]        mult_b,
  input  logic [15:0]       mult_p,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  y_acc,
  output logic [7:0]        y_q
);

  localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX     = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN     = ACC_W'(-128);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic                     rd_v;
  logic signed [ACC_W-1:0]  acc;
  logic signed [15:0]       bias_q;
  logic                     relu_q;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  shift_c;
  logic [7:0]               yq_c;

  // RAM read data goes straight to the shared multiplier
  assign mult_a     = x_in;
  assign mult_b     = w_in;
  assign prod_ext_c = ACC_W'($signed(mult_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (addr == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bias, ReLU and arithmetic shift with saturation to a signed byte
  always_comb begin
    sum_c = acc + ACC_W'(bias_q);
    if (relu_q && sum_c[ACC_W-1]) sum_c = '0;
    shift_c = sum_c >>> OUT_SHIFT;
    if (shift_c > Q_MAX)      yq_c = 8'h7f;
    else if (shift_c < Q_MIN) yq_c = 8'h80;
    else                      yq_c = shift_c[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      rd_v   <= 1'b0;
      acc    <= '0;
      bias_q <= '0;
      relu_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y_acc  <= '0;
      y_q    <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_d != S_IDLE);
      // rd_v marks the cycle the RAM data for a FETCH address is present
      rd_v <= (state_q == S_FETCH);
      if (rd_v) acc <= acc + prod_ext_c;
      case (state_q)
        S_IDLE: begin
          addr <= '0;
          if (start) begin
            acc    <= '0;
            bias_q <= $signed(bias);
            relu_q <= relu_en;
          end
        end
        S_FETCH: if (addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
        S_OUT: begin
          y_acc <= sum_c;
          y_q   <= yq_c;
          done  <= 1'b1;
          addr  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq with N_INPUTS=4: models the input/weight RAMs and
// the multiplier, and checks results against a plain-arithmetic neuron model.
module tb_neuron_mac_seq;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        relu_en;
  logic [1:0]  addr;
  logic [7:0]  x_in;
  logic [7:0]  w_in;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [15:0] mult_p;
  logic        busy;
  logic        done;
  logic [23:0] y_acc;
  logic [7:0]  y_q;

  logic signed [7:0]  xmem [N];
  logic signed [7:0]  wmem [N];
  logic signed [15:0] ma, mb;

  int errors = 0;
  int checks = 0;

  neuron_mac_seq #(
    .N_INPUTS (N),
    .ADDR_W   (2),
    .ACC_W    (24),
    .OUT_SHIFT(7)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bias   (bias),
    .relu_en(relu_en),
    .addr   (addr),
    .x_in   (x_in),
    .w_in   (w_in),
    .mult_a (mult_a),
    .mult_b (mult_b),
    .mult_p (mult_p),
    .busy   (busy),
    .done   (done),
    .y_acc  (y_acc),
    .y_q    (y_q)
  );

  always #5 clk = ~clk;

  // Registered-read RAMs and a combinational signed multiplier
  always @(posedge clk) begin
    x_in <= xmem[addr];
    w_in <= wmem[addr];
  end
  assign ma     = {{8{mult_a[7]}}, mult_a};
  assign mb     = {{8{mult_b[7]}}, mult_b};
  assign mult_p = ma * mb;

  function automatic void model(input int relu, input int b, output int yacc, output int yq);
    int s;
    s = b;
    for (int i = 0; i < N; i++) s += int'(xmem[i]) * int'(wmem[i]);
    if (relu != 0 && s < 0) s = 0;
    yacc = s;
    if (s >= 0) yq = s / 128;
    else        yq = -((-s + 127) / 128);
    if (yq > 127)  yq = 127;
    if (yq < -128) yq = -128;
  endfunction

  task automatic load(input int x0, x1, x2, x3, w0, w1, w2, w3);
    xmem[0] = 8'(x0); xmem[1] = 8'(x1); xmem[2] = 8'(x2); xmem[3] = 8'(x3);
    wmem[0] = 8'(w0); wmem[1] = 8'(w1); wmem[2] = 8'(w2); wmem[3] = 8'(w3);
  endtask

  // Runs one evaluation; lat = cycles after the start edge until done is seen
  task automatic do_eval(input logic r, input int b, input int pulse_at,
                         output int lat, output int ndone);
    bias = 16'(b);
    relu_en = r;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bias = ~bias;
    relu_en = ~r;
    lat = -1;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1 start = (k == pulse_at);
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++; if (addr !== 2'd0)   begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (y_acc !== 24'd0) begin errors++; $display("FAIL reset_y_acc: got %0d expected 0", y_acc); end
    checks++; if (y_q !== 8'd0)    begin errors++; $display("FAIL reset_y_q: got %0d expected 0", y_q); end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_directed;
    int lat, nd;
    int ea [5] = '{1280, 64516, -65024, 0, -10};
    int eq [5] = '{10, 127, -128, 0, -1};
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: begin load(16, 32, 48, 64, 8, 8, 8, 8); do_eval(1'b0, 0, 0, lat, nd); end
        1: begin load(127, 127, 127, 127, 127, 127, 127, 127); do_eval(1'b0, 0, 0, lat, nd); end
        2: begin load(-128, -128, -128, -128, 127, 127, 127, 127); do_eval(1'b0, 0, 0, lat, nd); end
        3: begin load(-128, -128, -128, -128, 127, 127, 127, 127); do_eval(1'b1, 0, 0, lat, nd); end
        default: begin load(1, 2, 3, 4, 1, 1, 1, 1); do_eval(1'b0, -20, 0, lat, nd); end
      endcase
      checks++; if (lat !== 6) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 6", t, lat); end
      checks++; if (nd !== 1)  begin errors++; $display("FAIL dir%0d_done_count: got %0d expected 1", t, nd); end
      checks++; if (int'($signed(y_acc)) !== ea[t])
        begin errors++; $display("FAIL dir%0d_y_acc: got %0d expected %0d", t, $signed(y_acc), ea[t]); end
      checks++; if (int'($signed(y_q)) !== eq[t])
        begin errors++; $display("FAIL dir%0d_y_q: got %0d expected %0d", t, $signed(y_q), eq[t]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_after: got %0b expected 0", t, busy); end
    end
  endtask

  task automatic test_busy_ignore;
    int lat, nd;
    load(16, 32, 48, 64, 8, 8, 8, 8);
    do_eval(1'b0, 0, 2, lat, nd);
    checks++; if (nd !== 1)    begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    checks++; if (lat !== 6)   begin errors++; $display("FAIL ignore_latency: got %0d expected 6", lat); end
    checks++; if (int'($signed(y_acc)) !== 1280)
      begin errors++; $display("FAIL ignore_y_acc: got %0d expected 1280", $signed(y_acc)); end
  endtask

  task automatic test_back_to_back;
    int t0, t1, n;
    load(1, 2, 3, 4, 1, 1, 1, 1);
    bias = 16'(-20);
    relu_en = 1'b0;
    t0 = -1; t1 = -1; n = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      if (n >= 1 && k > t0) start = 1'b0;
      if (done) begin
        if (n == 0) t0 = k; else if (n == 1) t1 = k;
        n++;
      end
    end
    start = 1'b0;
    checks++; if (n !== 2)       begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n); end
    checks++; if (t0 !== 6)      begin errors++; $display("FAIL b2b_first_latency: got %0d expected 6", t0); end
    checks++; if (t1 - t0 !== 7) begin errors++; $display("FAIL b2b_spacing: got %0d expected 7", t1 - t0); end
    checks++; if (int'($signed(y_acc)) !== -10)
      begin errors++; $display("FAIL b2b_y_acc: got %0d expected -10", $signed(y_acc)); end
  endtask

  task automatic test_reset_abort;
    int lat, nd;
    bit hit;
    load(16, 32, 48, 64, 8, 8, 8, 8);
    bias = 16'd0;
    relu_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (addr == 2'd2) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach_addr2: got addr %0d expected 2", addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %0b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (addr !== 2'd0)   begin errors++; $display("FAIL abort_addr: got %0d expected 0", addr); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (y_acc !== 24'd0) begin errors++; $display("FAIL abort_y_acc: got %0d expected 0", y_acc); end
    checks++; if (y_q !== 8'd0)    begin errors++; $display("FAIL abort_y_q: got %0d expected 0", y_q); end
    @(negedge clk) rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
    do_eval(1'b0, 0, 0, lat, nd);
    checks++; if (int'($signed(y_acc)) !== 1280 || int'($signed(y_q)) !== 10)
      begin errors++; $display("FAIL abort_rerun: got %0d/%0d expected 1280/10", $signed(y_acc), $signed(y_q)); end
  endtask

  task automatic test_random;
    int lat, nd, ea, eq, b;
    logic r;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        xmem[i] = 8'($urandom);
        wmem[i] = 8'($urandom);
      end
      b = int'($signed(16'($urandom)));
      r = 1'($urandom);
      model(int'(r), b, ea, eq);
      do_eval(r, b, 0, lat, nd);
      checks++; if (lat !== 6 || nd !== 1)
        begin errors++; $display("FAIL rand%0d_timing: got lat %0d n %0d expected 6 1", t, lat, nd); end
      checks++; if (int'($signed(y_acc)) !== ea)
        begin errors++; $display("FAIL rand%0d_y_acc: got %0d expected %0d", t, $signed(y_acc), ea); end
      checks++; if (int'($signed(y_q)) !== eq)
        begin errors++; $display("FAIL rand%0d_y_q: got %0d expected %0d", t, $signed(y_q), eq); end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    relu_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      xmem[i] = '0;
      wmem[i] = '0;
    end
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
